// File: rtl/dm_pkg.sv
// Shared debug-module types and constants for the system-bus arbiter.
package dm_pkg;

  typedef enum logic [1:0] {
    SbaArbIdle,
    SbaArbReq,
    SbaArbResp
  } sba_arb_state_e;

  localparam int unsigned SbaArbTimeoutDefault = 1024;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dm_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i.
module dm_rr_pick #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] onehot_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  // Scan from the pointer, wrapping modulo NumReq; the first hit wins.
  always_comb begin
    int unsigned cand;
    cand     = 0;
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = (32'(ptr_i) + i) % NumReq;
      if (!valid_o && req_i[cand[IdxW-1:0]]) begin
        valid_o                     = 1'b1;
        idx_o                       = cand[IdxW-1:0];
        onehot_o[cand[IdxW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_sba_arb.sv
// Round-robin arbiter sharing one system-bus master port between requesters,
// one outstanding transaction, response routing and a response watchdog.
module dm_sba_arb
  import dm_pkg::*;
#(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = SbaArbTimeoutDefault,
  localparam int unsigned IdxW         = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned BeW          = BusWidth / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             dmactive_i,
  input  logic [NumReq-1:0]                req_i,
  input  logic [NumReq-1:0][BusWidth-1:0]  add_i,
  input  logic [NumReq-1:0]                we_i,
  input  logic [NumReq-1:0][BusWidth-1:0]  wdata_i,
  input  logic [NumReq-1:0][BeW-1:0]       be_i,
  output logic [NumReq-1:0]                gnt_o,
  output logic [NumReq-1:0]                r_valid_o,
  output logic [NumReq-1:0]                r_err_o,
  output logic [BusWidth-1:0]              r_rdata_o,
  output logic                             master_req_o,
  output logic [BusWidth-1:0]              master_add_o,
  output logic                             master_we_o,
  output logic [BusWidth-1:0]              master_wdata_o,
  output logic [BeW-1:0]                   master_be_o,
  input  logic                             master_gnt_i,
  input  logic                             master_r_valid_i,
  input  logic [BusWidth-1:0]              master_r_rdata_i,
  output logic                             busy_o,
  output logic [IdxW-1:0]                  owner_o
);

  localparam int unsigned CntW        = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned TimeoutLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;

  sba_arb_state_e    state_q, state_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [NumReq-1:0] pick_onehot;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_valid;

  logic              active;
  logic              mreq;
  logic [IdxW-1:0]   sel;

  assign active    = rst_ni & dmactive_i;
  assign r_rdata_o = master_r_rdata_i;

  dm_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) i_rr_pick (
    .req_i    (req_i),
    .ptr_i    (rr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Next-state, grant/response routing and master-port forwarding.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    cnt_d     = '0;
    gnt_o     = '0;
    r_valid_o = '0;
    r_err_o   = '0;
    mreq      = 1'b0;
    sel       = owner_q;

    unique case (state_q)
      SbaArbIdle: begin
        if (pick_valid) begin
          mreq    = 1'b1;
          sel     = pick_idx;
          owner_d = pick_idx;
          if (master_gnt_i) begin
            gnt_o   = pick_onehot;
            rr_d    = IdxW'(rr_next(32'(pick_idx), NumReq));
            state_d = SbaArbResp;
          end else begin
            state_d = SbaArbReq;
          end
        end
      end
      SbaArbReq: begin
        // A dropped request stops forwarding, so no grant reaches the owner.
        mreq = req_i[owner_q];
        if (mreq && master_gnt_i) begin
          gnt_o[owner_q] = 1'b1;
          rr_d           = IdxW'(rr_next(32'(owner_q), NumReq));
          state_d        = SbaArbResp;
        end
      end
      SbaArbResp: begin
        cnt_d = cnt_q + 1'b1;
        if (master_r_valid_i) begin
          r_valid_o[owner_q] = 1'b1;
          state_d            = SbaArbIdle;
          cnt_d              = '0;
        end else if (TimeoutCycles != 0 && cnt_q == CntW'(TimeoutLast)) begin
          r_valid_o[owner_q] = 1'b1;
          r_err_o[owner_q]   = 1'b1;
          state_d            = SbaArbIdle;
          cnt_d              = '0;
        end
      end
      default: state_d = SbaArbIdle;
    endcase

    if (!active) begin
      state_d   = SbaArbIdle;
      rr_d      = '0;
      owner_d   = '0;
      cnt_d     = '0;
      gnt_o     = '0;
      r_valid_o = '0;
      r_err_o   = '0;
      mreq      = 1'b0;
    end

    master_req_o   = mreq;
    master_add_o   = mreq ? add_i[sel]   : '0;
    master_we_o    = mreq ? we_i[sel]    : 1'b0;
    master_wdata_o = mreq ? wdata_i[sel] : '0;
    master_be_o    = mreq ? be_i[sel]    : '0;
    busy_o         = active && (state_q != SbaArbIdle);
    owner_o        = active ? owner_q : '0;
  end

  // State, pointer, owner and watchdog registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SbaArbIdle;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(r_valid_o));
  a_no_req_in_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    master_req_o |-> (state_q != SbaArbResp));
  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni || !dmactive_i)
    (state_q == SbaArbReq) |-> req_i[owner_q])
    else $error("sba arbiter: requester %0d dropped req_i before grant", owner_q);

endmodule

// File: tb/tb_dm_sba_arb.sv
module tb_dm_sba_arb;

  localparam int unsigned BW = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned TO = 8;
  localparam int unsigned IW = 1;
  localparam int unsigned BE = BW / 8;

  logic clk = 1'b0;
  logic rst_n, dmactive;
  logic [NR-1:0]          req, we;
  logic [NR-1:0][BW-1:0]  add, wdata;
  logic [NR-1:0][BE-1:0]  be;
  logic [NR-1:0]          gnt_o, r_valid_o, r_err_o;
  logic [BW-1:0]          r_rdata_o;
  logic                   master_req_o, master_we_o;
  logic [BW-1:0]          master_add_o, master_wdata_o;
  logic [BE-1:0]          master_be_o;
  logic                   mgnt, mrv;
  logic [BW-1:0]          mrdata;
  logic                   busy_o;
  logic [IW-1:0]          owner_o;

  always #5 clk = ~clk;

  dm_sba_arb #(
    .BusWidth      (BW),
    .NumReq        (NR),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .dmactive_i       (dmactive),
    .req_i            (req),
    .add_i            (add),
    .we_i             (we),
    .wdata_i          (wdata),
    .be_i             (be),
    .gnt_o            (gnt_o),
    .r_valid_o        (r_valid_o),
    .r_err_o          (r_err_o),
    .r_rdata_o        (r_rdata_o),
    .master_req_o     (master_req_o),
    .master_add_o     (master_add_o),
    .master_we_o      (master_we_o),
    .master_wdata_o   (master_wdata_o),
    .master_be_o      (master_be_o),
    .master_gnt_i     (mgnt),
    .master_r_valid_i (mrv),
    .master_r_rdata_i (mrdata),
    .busy_o           (busy_o),
    .owner_o          (owner_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level reference: who holds the bus, whether it is still
  // waiting for a grant or for its answer, and the cycle the grant happened.
  bit            m_busy, m_granted;
  logic [IW-1:0] m_owner, m_ptr;
  int            m_tgrant;
  int            cyc = 0;

  logic [NR-1:0] e_gnt, e_rv, e_err;
  logic          e_mreq, e_has;
  logic [IW-1:0] e_w;
  logic [127:0]  e_fields;

  function automatic logic [IW-1:0] succ(input logic [IW-1:0] x);
    return IW'((32'(x) + 1) % NR);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_granted = 0; m_owner = '0; m_ptr = '0; m_tgrant = 0;
  endtask

  task automatic model_eval();
    logic [IW-1:0] k, s;
    e_gnt = '0; e_rv = '0; e_err = '0; e_mreq = 0; e_has = 0; e_w = '0;
    e_fields = '0; s = '0;
    if (rst_n && dmactive) begin
      if (!m_busy) begin
        for (int unsigned off = 0; off < NR; off++) begin
          k = IW'((32'(m_ptr) + off) % NR);
          if (!e_has && req[k]) begin e_has = 1; e_w = k; end
        end
        if (e_has) begin
          e_mreq = 1; s = e_w;
          if (mgnt) e_gnt[e_w] = 1'b1;
        end
      end else if (!m_granted) begin
        s = m_owner;
        e_mreq = req[m_owner];
        if (e_mreq && mgnt) e_gnt[m_owner] = 1'b1;
      end else if (mrv) begin
        e_rv[m_owner] = 1'b1;
      end else if (cyc - m_tgrant == int'(TO)) begin
        e_rv[m_owner] = 1'b1; e_err[m_owner] = 1'b1;
      end
      if (e_mreq) e_fields = 128'({we[s], be[s], wdata[s], add[s]});
    end
  endtask

  task automatic model_update();
    if (!rst_n || !dmactive) model_reset();
    else if (!m_busy) begin
      if (e_has) begin
        m_owner = e_w; m_busy = 1;
        if (|e_gnt) begin m_granted = 1; m_ptr = succ(e_w); m_tgrant = cyc; end
      end
    end else if (!m_granted) begin
      if (|e_gnt) begin m_granted = 1; m_ptr = succ(m_owner); m_tgrant = cyc; end
    end else if (|e_rv) begin
      m_busy = 0; m_granted = 0;
    end
    cyc++;
  endtask

  task automatic compare_all();
    logic act_on;
    act_on = rst_n && dmactive;
    check("gnt_o", 128'(gnt_o), 128'(e_gnt));
    check("r_valid_o", 128'(r_valid_o), 128'(e_rv));
    check("r_err_o", 128'(r_err_o), 128'(e_err));
    check("master_req_o", 128'(master_req_o), 128'(e_mreq));
    if (e_mreq || !act_on)
      check("master_fields", 128'({master_we_o, master_be_o, master_wdata_o, master_add_o}), e_fields);
    check("busy_o", 128'(busy_o), 128'(act_on && m_busy));
    check("owner_o", 128'(owner_o), 128'(act_on ? m_owner : '0));
    check("r_rdata_o", 128'(r_rdata_o), 128'(mrdata));
  endtask

  task automatic settle();
    #4;
    model_eval();
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; mgnt = 0; mrv = 0; mrdata = '0;
  endtask

  task automatic reset_dut();
    rst_n = 0; idle_inputs(); model_reset();
    @(posedge clk); #1;
    rst_n = 1; dmactive = 1;
  endtask

  typedef struct {
    logic          dma;
    logic [NR-1:0] rq;
    logic          mg;
    logic [NR-1:0] egnt;
    logic          emreq;
    logic [BW-1:0] eadd;
  } vec_t;

  localparam logic [BW-1:0] A0 = 32'h1000_0000;
  localparam logic [BW-1:0] A1 = 32'h2000_0004;

  vec_t            vt[6];
  int unsigned     gq[$];
  logic [NR-1:0]   granted_last;
  bit   [NR-1:0]   pending;

  initial begin
    vt[0] = '{1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 32'h0};
    vt[1] = '{1'b1, 2'b01, 1'b0, 2'b00, 1'b1, A0};
    vt[2] = '{1'b1, 2'b01, 1'b1, 2'b01, 1'b1, A0};
    vt[3] = '{1'b1, 2'b10, 1'b1, 2'b10, 1'b1, A1};
    vt[4] = '{1'b1, 2'b11, 1'b1, 2'b01, 1'b1, A0};
    vt[5] = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 32'h0};

    add = '0; wdata = '0; we = '0; be = '0;
    add[0] = A0; add[1] = A1; wdata[0] = 32'h0123_4567; wdata[1] = 32'h89ab_cdef;
    be[0] = 4'hf; be[1] = 4'h3; we[1] = 1'b1;
    model_reset();

    // Reset state: outputs zero even with requests and grant pending.
    rst_n = 0; dmactive = 1; req = 2'b11; mgnt = 1; mrv = 1; mrdata = 32'h5a5a_0001;
    settle();
    advance();
    idle_inputs(); rst_n = 1;

    // Idle arbitration from pointer 0, no clock edges between vectors.
    for (int unsigned i = 0; i < 6; i++) begin
      dmactive = vt[i].dma; req = vt[i].rq; mgnt = vt[i].mg;
      #1;
      check("tbl_gnt", 128'(gnt_o), 128'(vt[i].egnt));
      check("tbl_mreq", 128'(master_req_o), 128'(vt[i].emreq));
      if (vt[i].emreq || !vt[i].dma) check("tbl_add", 128'(master_add_o), 128'(vt[i].eadd));
    end
    idle_inputs(); dmactive = 1;
    @(posedge clk); #1;

    // Single read: grant in cycle 0, answer in cycle 3, idle in cycle 4.
    reset_dut();
    req[0] = 1; mgnt = 1; settle(); check("s1_gnt", 128'(gnt_o), 128'(2'b01)); advance();
    req = '0; mgnt = 0; settle(); advance();
    settle(); advance();
    mrv = 1; mrdata = 32'hDEAD_BEEF; settle();
    check("s1_rvalid", 128'(r_valid_o), 128'(2'b01));
    check("s1_rdata", 128'(r_rdata_o), 128'(32'hDEAD_BEEF));
    advance();
    mrv = 0; settle(); check("s1_busy_low", 128'(busy_o), 128'(0)); advance();

    // Both requesting continuously, immediate grant, 1-cycle answers.
    reset_dut();
    gq.delete();
    req = 2'b11; mgnt = 1; mrv = 1; mrdata = 32'h0000_1111;
    for (int unsigned c = 0; c < 8; c++) begin
      settle();
      if (gnt_o[0]) gq.push_back(0);
      if (gnt_o[1]) gq.push_back(1);
      advance();
    end
    check("s2_ngrants", 128'(gq.size()), 128'(4));
    for (int unsigned i = 0; i < 4 && i < gq.size(); i++)
      check("s2_order", 128'(gq[i]), 128'(i % 2));

    // Requester 0 locked in Req while requester 1 waits.
    reset_dut();
    req[0] = 1;
    for (int unsigned c = 0; c < 5; c++) begin
      if (c == 1) req[1] = 1;
      settle();
      check("s3_add_locked", 128'(master_add_o), 128'(A0));
      check("s3_no_gnt", 128'(gnt_o), 128'(0));
      advance();
    end
    mgnt = 1; settle(); check("s3_gnt0", 128'(gnt_o), 128'(2'b01)); advance();
    req[0] = 0; mgnt = 0; settle(); check("s3_wait", 128'(gnt_o), 128'(0)); advance();
    mrv = 1; settle(); check("s3_rv0", 128'(r_valid_o), 128'(2'b01)); advance();
    mrv = 0; mgnt = 1; settle(); check("s3_gnt1", 128'(gnt_o), 128'(2'b10)); advance();
    req = '0; mgnt = 0; mrv = 1; settle(); advance();
    mrv = 0;

    // Watchdog: error response exactly TO cycles after grant.
    reset_dut();
    req[0] = 1; mgnt = 1; settle(); advance();
    req = '0; mgnt = 0;
    for (int unsigned c = 1; c < TO; c++) begin
      settle(); check("s4_no_rv", 128'(r_valid_o), 128'(0)); advance();
    end
    settle();
    check("s4_to_rv", 128'(r_valid_o), 128'(2'b01));
    check("s4_to_err", 128'(r_err_o), 128'(2'b01));
    advance();
    mrv = 1; settle(); check("s4_late_drop", 128'(r_valid_o), 128'(0)); advance();
    mrv = 0; req[1] = 1; mgnt = 1; settle(); check("s4_next_gnt", 128'(gnt_o), 128'(2'b10)); advance();
    req = '0; mgnt = 0; mrv = 1; settle(); check("s4_next_err", 128'(r_err_o), 128'(0)); advance();
    mrv = 0;

    // dmactive drop during Resp.
    reset_dut();
    req[0] = 1; mgnt = 1; settle(); advance();
    req = '0; mgnt = 0; dmactive = 0; settle();
    check("s5_mreq_clr", 128'(master_req_o), 128'(0)); advance();
    dmactive = 1; mrv = 1; settle();
    check("s5_busy", 128'(busy_o), 128'(0));
    check("s5_drop", 128'(r_valid_o), 128'(0)); advance();
    mrv = 0; req = 2'b11; mgnt = 1; settle(); check("s5_ptr0", 128'(gnt_o), 128'(2'b01)); advance();
    req = 2'b10; mgnt = 0; mrv = 1; settle(); advance();
    mrv = 0; mgnt = 1; settle(); advance();
    req = '0; mgnt = 0; mrv = 1; settle(); advance();
    mrv = 0;

    // Asynchronous reset while requester 1 is locked in Req.
    reset_dut();
    req[0] = 1; mgnt = 1; settle(); advance();
    req = '0; mgnt = 0; mrv = 1; settle(); advance();
    mrv = 0; req[1] = 1; settle(); check("s6_add1", 128'(master_add_o), 128'(A1)); advance();
    settle(); check("s6_in_req", 128'(master_req_o), 128'(1));
    #1 rst_n = 0;
    #1;
    check("s6_mreq_zero", 128'(master_req_o), 128'(0));
    check("s6_busy_zero", 128'(busy_o), 128'(0));
    check("s6_owner_zero", 128'(owner_o), 128'(0));
    check("s6_add_zero", 128'(master_add_o), 128'(0));
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    req = 2'b11; mgnt = 1; settle(); check("s6_resume_ptr0", 128'(gnt_o), 128'(2'b01)); advance();
    req = 2'b10; mgnt = 0; mrv = 1; settle(); advance();
    mrv = 0; mgnt = 1; settle(); advance();
    req = '0; mgnt = 0; mrv = 1; settle(); advance();

    // Randomized traffic against the reference model.
    reset_dut();
    pending = '0; granted_last = '0;
    for (int unsigned c = 0; c < 600; c++) begin
      for (int unsigned k = 0; k < NR; k++) begin
        if (granted_last[IW'(k)]) begin
          pending[IW'(k)] = 0; req[IW'(k)] = 0;
        end else if (!pending[IW'(k)] && $urandom_range(0, 3) == 0) begin
          pending[IW'(k)] = 1; req[IW'(k)] = 1;
          add[IW'(k)]   = $urandom;
          wdata[IW'(k)] = $urandom;
          we[IW'(k)]    = 1'($urandom_range(0, 1));
          be[IW'(k)]    = 4'($urandom_range(0, 15));
        end
      end
      mgnt     = ($urandom_range(0, 1) == 0);
      mrv      = ($urandom_range(0, 5) == 0);
      mrdata   = $urandom;
      dmactive = ($urandom_range(0, 79) != 0);
      settle();
      granted_last = e_gnt;
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
